pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_stage_reg_sat_counter.sv | 30 +++
 rtl/pipe_stage_reg.sv | 127 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the parametrised pipeline stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_CHANNELS = 4;

    // Extract channel k from a default-shaped payload bus.
    function automatic logic [DEF_WIDTH-1:0] chan_slice(
        input logic [DEF_WIDTH*DEF_CHANNELS-1:0] bus,
        input int                                k
    );
        return bus[k*DEF_WIDTH +: DEF_WIDTH];
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter; holds at all-ones, cleared only by reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// synchronous flush and a saturating stall-cycle counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SKID     = 1,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*CHANNELS-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH*CHANNELS-1:0] out_data,
    output logic [1:0]                occupancy,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int BUS_W = WIDTH * CHANNELS;

    stage_state_t     state_q, state_d;
    logic [BUS_W-1:0] main_q, main_d;
    logic [BUS_W-1:0] skid_q, skid_d;
    logic             in_acc;
    logic             out_tk;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign in_acc    = in_valid & in_ready;
    assign out_tk    = out_valid & out_ready;

    // Payload registers only change on an accepted beat or a skid promotion.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_acc) begin
                    state_d = ST_ONE;
                    main_d  = in_data;
                end
            end
            ST_ONE: begin
                if (in_acc && out_tk) begin
                    main_d = in_data;
                end else if (in_acc) begin
                    state_d = ST_TWO;
                    skid_d  = in_data;
                end else if (out_tk) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_tk) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            // Registered ready: no combinational path from out_ready.
            logic in_ready_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != ST_TWO);
                end
            end
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ST_ONE:  occupancy = 2'd1;
            ST_TWO:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid && !out_ready && !flush),
        .count (stall_cnt)
    );

    a_in_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && !in_ready) |=> (!in_valid || $stable(in_data)));

    a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: skid (32x4) and no-skid (8x2) instances.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: SKID=1, 4x32, 4-bit stall counter
    logic         a_fl = 0, a_iv = 0, a_irdy, a_ovld, a_ordy = 0;
    logic [127:0] a_data = '0, a_odata;
    logic [1:0]   a_occ;
    logic [3:0]   a_stall;

    // Instance B: SKID=0, 2x8, 16-bit stall counter
    logic         b_fl = 0, b_iv = 0, b_irdy, b_ovld, b_ordy = 0;
    logic [15:0]  b_data = '0, b_odata;
    logic [1:0]   b_occ;
    logic [15:0]  b_stall;

    pipe_stage_reg #(.WIDTH(32), .CHANNELS(4), .SKID(1), .CNT_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_fl),
        .in_valid(a_iv), .in_ready(a_irdy), .in_data(a_data),
        .out_valid(a_ovld), .out_ready(a_ordy), .out_data(a_odata),
        .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_stage_reg #(.WIDTH(8), .CHANNELS(2), .SKID(0), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_fl),
        .in_valid(b_iv), .in_ready(b_irdy), .in_data(b_data),
        .out_valid(b_ovld), .out_ready(b_ordy), .out_data(b_odata),
        .occupancy(b_occ), .stall_cnt(b_stall)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] qa[$];
    logic [15:0]  qb[$];
    int           a_stall_m = 0;
    int           b_stall_m = 0;
    logic         a_last_acc, b_last_acc;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock of instance A: drive, check against the model, then advance it.
    task automatic cycle_a(input logic iv, input logic [127:0] d, input logic ordy, input logic fl);
        logic acc, tk, had_v;
        @(negedge clk);
        a_iv = iv; a_data = d; a_ordy = ordy; a_fl = fl;
        #1;
        had_v = (qa.size() != 0);
        check_val("a_out_valid", a_ovld, had_v);
        check_val("a_occupancy", a_occ, qa.size());
        check_val("a_in_ready", a_irdy, qa.size() != 2);
        check_val("a_stall_cnt", a_stall, a_stall_m);
        if (had_v) check_val("a_out_data", a_odata, qa[0]);
        acc = iv && (qa.size() != 2);
        tk  = had_v && ordy;
        a_last_acc = acc;
        @(posedge clk);
        if (tk) void'(qa.pop_front());
        if (fl) qa.delete();
        else if (acc) qa.push_back(d);
        if (had_v && !ordy && !fl && a_stall_m != 15) a_stall_m++;
    endtask

    task automatic cycle_b(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
        logic acc, tk, had_v;
        @(negedge clk);
        b_iv = iv; b_data = d; b_ordy = ordy; b_fl = fl;
        #1;
        had_v = (qb.size() != 0);
        check_val("b_out_valid", b_ovld, had_v);
        check_val("b_occupancy", b_occ, qb.size());
        check_val("b_in_ready", b_irdy, !had_v || ordy);
        check_val("b_stall_cnt", b_stall, b_stall_m);
        if (had_v) check_val("b_out_data", b_odata, qb[0]);
        acc = iv && (!had_v || ordy);
        tk  = had_v && ordy;
        b_last_acc = acc;
        @(posedge clk);
        if (tk) void'(qb.pop_front());
        if (fl) qb.delete();
        else if (acc) qb.push_back(d);
        if (had_v && !ordy && !fl) b_stall_m++;
    endtask

    initial begin
        logic [127:0] d;
        logic [15:0]  bd;
        logic         iv, ordy, fl, pend;

        // Reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_a_out_valid", a_ovld, 0);
        check_val("rst_a_in_ready", a_irdy, 1);
        check_val("rst_a_occupancy", a_occ, 0);
        check_val("rst_a_stall", a_stall, 0);
        check_val("rst_a_out_data", a_odata, 0);
        check_val("rst_b_out_valid", b_ovld, 0);
        check_val("rst_b_in_ready", b_irdy, 1);
        check_val("rst_b_out_data", b_odata, 0);
        b_ordy = 1'b1;

        // Back-to-back stream with out_ready held high
        cycle_a(1, {32'h22, 32'h11, 32'h4, 32'h100}, 1, 0);
        cycle_a(1, {32'h22, 32'h11, 32'h4, 32'h104}, 1, 0);
        cycle_a(1, {32'h22, 32'h11, 32'h4, 32'h108}, 1, 0);
        cycle_a(0, '0, 1, 0);
        cycle_a(0, '0, 1, 0);
        check_val("stream_stall", a_stall, 0);

        // Fill both entries while stalled, then drain in order
        cycle_a(1, 128'hA, 0, 0);
        cycle_a(1, 128'hB, 0, 0);
        cycle_a(0, '0, 0, 0);
        cycle_a(0, '0, 0, 0);
        cycle_a(0, '0, 1, 0);
        cycle_a(0, '0, 1, 0);
        cycle_a(0, '0, 1, 0);

        // Flush while full with a new beat offered on the same edge
        cycle_a(1, 128'hD, 0, 0);
        cycle_a(1, 128'hE, 0, 0);
        cycle_a(1, 128'hC, 0, 1);
        cycle_a(0, '0, 1, 0);
        cycle_a(0, '0, 1, 0);

        // Flush while one entry is delivered and a new beat is accepted
        cycle_a(1, 128'hF, 0, 0);
        cycle_a(1, 128'h1C, 1, 1);
        cycle_a(0, '0, 1, 0);
        cycle_a(0, '0, 1, 0);

        // Random traffic; offered-but-refused data is held until accepted
        pend = 0;
        d = '0;
        for (int i = 0; i < 200; i++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 15) == 0);
            if (!pend) d = {$urandom, $urandom, $urandom, $urandom};
            cycle_a(iv, d, ordy, fl);
            pend = iv && !a_last_acc;
        end
        repeat (3) cycle_a(0, '0, 1, 0);

        // No-skid instance: out_ready toggling with continuous input
        bd = 16'h0101;
        for (int i = 0; i < 12; i++) begin
            cycle_b(1, bd, (i % 2) == 0, 0);
            if (b_last_acc) bd = bd + 16'h0102;
        end
        repeat (2) cycle_b(0, '0, 1, 0);
        for (int i = 0; i < 40; i++) begin
            ordy = ($urandom_range(0, 1) != 0);
            iv   = ($urandom_range(0, 3) != 0);
            cycle_b(iv, bd, ordy, ($urandom_range(0, 15) == 0));
            if (b_last_acc || !iv) bd = 16'($urandom);
        end
        repeat (2) cycle_b(0, '0, 1, 0);

        // Stall counter saturation, then asynchronous reset mid-stall
        cycle_a(1, 128'h5A5A, 0, 0);
        for (int i = 0; i < 20; i++) cycle_a(0, '0, 0, 0);
        check_val("sat_stall", a_stall, 15);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_out_valid", a_ovld, 0);
        check_val("arst_occupancy", a_occ, 0);
        check_val("arst_stall", a_stall, 0);
        check_val("arst_out_data", a_odata, 0);
        check_val("arst_in_ready", a_irdy, 1);
        qa.delete();
        a_stall_m = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle_a(0, '0, 1, 0);
        cycle_a(1, 128'h77, 1, 0);
        cycle_a(0, '0, 1, 0);
        cycle_a(0, '0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
